// File: rtl/closing3x3_if.sv
// Pixel-stream bundle for closing3x3: clock enable, input pixel with syncs,
// and the closed pixel with its delayed syncs.
interface closing3x3_if;
  logic ce;
  logic mask;
  logic in_de;
  logic in_hsync;
  logic in_vsync;
  logic closed;
  logic out_de;
  logic out_hsync;
  logic out_vsync;

  modport master (
    output ce, mask, in_de, in_hsync, in_vsync,
    input  closed, out_de, out_hsync, out_vsync
  );

  modport slave (
    input  ce, mask, in_de, in_hsync, in_vsync,
    output closed, out_de, out_hsync, out_vsync
  );
endinterface

// File: rtl/closing3x3.sv
// Binary 3x3 morphological closing (dilate then erode) on a streamed mask,
// with de/hsync/vsync carried through the same delay path.
module closing3x3_stage #(
  parameter logic [9:0] H_SIZE = 10'd83,
  parameter bit         ERODE  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       hold_zero,
  input  logic [3:0] pix,    // {vsync, hsync, de, value}
  output logic [3:0] res     // centre {vsync, hsync, de} plus filtered value
);
  localparam int unsigned DEPTH = int'(H_SIZE);
  localparam int unsigned AW    = $clog2(DEPTH);

  // Row 1 carries syncs so the centre pixel brings them along; row 2 needs only {de,value}.
  logic [3:0] lb_a [DEPTH];
  logic [1:0] lb_b [DEPTH];
  logic [9:0] ptr;
  logic [3:0] row_a;
  logic [1:0] row_b;
  logic [1:0] w0a, w0b, w1b, w2a, w2b;
  logic [3:0] w1a;
  logic [1:0] win [9];
  logic       acc;
  logic       val;

  assign row_a = lb_a[ptr[AW-1:0]];
  assign row_b = lb_b[ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (ce) begin
      lb_a[ptr[AW-1:0]] <= pix;
      lb_b[ptr[AW-1:0]] <= row_a[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      w0a <= '0;
      w0b <= '0;
      w1a <= '0;
      w1b <= '0;
      w2a <= '0;
      w2b <= '0;
      res <= '0;
    end else if (ce) begin
      ptr <= (ptr == H_SIZE - 10'd1) ? '0 : ptr + 10'd1;
      w0a <= pix[1:0];
      w0b <= w0a;
      w1a <= row_a;
      w1b <= w1a[1:0];
      w2a <= row_b;
      w2b <= w2a;
      res <= hold_zero ? '0 : {w1a[3:1], val};
    end
  end

  // Newest column is combinational (pix/row_a/row_b) so the centre sits H_SIZE+1 back.
  always_comb begin
    win[0] = pix[1:0];
    win[1] = w0a;
    win[2] = w0b;
    win[3] = row_a[1:0];
    win[4] = w1a[1:0];
    win[5] = w1b;
    win[6] = row_b;
    win[7] = w2a;
    win[8] = w2b;
    acc = ERODE;
    for (int unsigned i = 0; i < 9; i++) begin
      if (ERODE) acc = acc & (~win[i][1] | win[i][0]);
      else       acc = acc | (win[i][1] & win[i][0]);
    end
    val = w1a[1] & acc;
  end
endmodule

module closing3x3 #(
  parameter logic [9:0] H_SIZE = 10'd83
) (
  input logic        clk,
  input logic        rst,
  closing3x3_if.slave bus
);
  localparam logic [11:0] LAT = 12'(2 * int'(H_SIZE) + 4);

  logic [11:0] fill_cnt;
  logic        fill_done;
  logic [3:0]  s1;
  logic [3:0]  s2;

  // Output register is loaded on the edge that makes the count reach LAT.
  assign fill_done = (fill_cnt >= LAT - 12'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (bus.ce && fill_cnt != LAT) begin
      fill_cnt <= fill_cnt + 12'd1;
    end
  end

  closing3x3_stage #(.H_SIZE(H_SIZE), .ERODE(1'b0)) u_dilate (
    .clk       (clk),
    .rst       (rst),
    .ce        (bus.ce),
    .hold_zero (1'b0),
    .pix       ({bus.in_vsync, bus.in_hsync, bus.in_de, bus.mask}),
    .res       (s1)
  );

  closing3x3_stage #(.H_SIZE(H_SIZE), .ERODE(1'b1)) u_erode (
    .clk       (clk),
    .rst       (rst),
    .ce        (bus.ce),
    .hold_zero (!fill_done),
    .pix       (s1),
    .res       (s2)
  );

  assign bus.closed    = s2[0];
  assign bus.out_de    = s2[1];
  assign bus.out_hsync = s2[2];
  assign bus.out_vsync = s2[3];
endmodule
